// File: rtl/average_ram_reader.sv
// average_ram_reader: fetches 9 packed lane words from a single-port RAM.
// Optional AVG_RD_OVERRUN_EN adds o_busy and a sticky o_overrun flag.
module average_ram_reader #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int NUM_WORDS = 9,
  parameter int RD_LAT    = 1
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_startRam,
  input  logic [NUM_WORDS*ADDR_W-1:0] i_addrRead,
  output logic                        o_validRam,
  output logic [NUM_WORDS*DATA_W-1:0] o_data,
  output logic                        o_memRe,
  output logic [ADDR_W-1:0]           o_memAddr,
  input  logic [DATA_W-1:0]           i_memData
`ifdef AVG_RD_OVERRUN_EN
  ,
  output logic                        o_busy,
  output logic                        o_overrun
`endif
);

  localparam int LW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    VALID
  } state_t;

  state_t state, nextState;

  logic [ADDR_W-1:0] addrLat [NUM_WORDS];
  logic [LW-1:0]     laneCnt;
  logic [LW-1:0]     nextLane;
  logic [LW-1:0]     nextIdx;
  logic [2:0]        drainCnt;
  logic              accept;
  logic              lastLane;
  logic              drainDone;
  logic              nextWrap;

  logic              pipeVld  [RD_LAT];
  logic [LW-1:0]     pipeLane [RD_LAT];

  assign accept    = i_startRam &&
                     (state == IDLE || state == VALID);
  assign lastLane  = (laneCnt == LW'(NUM_WORDS - 1));
  assign drainDone = (drainCnt == 3'(RD_LAT - 1));
  assign nextLane  = laneCnt + 1'b1;
  assign nextIdx   = lastLane ? laneCnt : nextLane;
  // a lane below lane0 means base+k overflowed the address space
  assign nextWrap  = addrLat[nextIdx] < addrLat[0];

  assign o_validRam = (state == VALID);

  // state register
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= nextState;
  end

  // next-state decode
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:  if (accept)    nextState = ISSUE;
      ISSUE: if (lastLane)  nextState = DRAIN;
      DRAIN: if (drainDone) nextState = VALID;
      VALID: if (accept)    nextState = ISSUE;
      default:              nextState = IDLE;
    endcase
  end

  // address latch, lane walk and registered RAM request
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_WORDS; i++)
        addrLat[i] <= '0;
      laneCnt   <= '0;
      drainCnt  <= '0;
      o_memRe   <= 1'b0;
      o_memAddr <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_WORDS; i++)
        addrLat[i] <= i_addrRead[i*ADDR_W +: ADDR_W];
      laneCnt   <= '0;
      drainCnt  <= '0;
      o_memRe   <= 1'b1;
      o_memAddr <= i_addrRead[ADDR_W-1:0];
    end else if (state == ISSUE) begin
      if (lastLane) begin
        o_memRe <= 1'b0;
      end else begin
        laneCnt   <= nextLane;
        o_memRe   <= !nextWrap;
        o_memAddr <= addrLat[nextIdx];
      end
    end else if (state == DRAIN) begin
      drainCnt <= drainCnt + 3'd1;
    end
  end

  // return pipeline tracks which lane each RAM word belongs to
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipeVld[i]  <= 1'b0;
        pipeLane[i] <= '0;
      end
    end else begin
      pipeVld[0]  <= o_memRe;
      pipeLane[0] <= laneCnt;
      for (int i = 1; i < RD_LAT; i++) begin
        pipeVld[i]  <= pipeVld[i-1];
        pipeLane[i] <= pipeLane[i-1];
      end
    end
  end

  // capture returning words; a new request clears the result
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_data <= '0;
    end else begin
      for (int k = 0; k < NUM_WORDS; k++)
        if (pipeVld[RD_LAT-1] &&
            pipeLane[RD_LAT-1] == LW'(k))
          o_data[k*DATA_W +: DATA_W] <= i_memData;
      if (accept)
        o_data <= '0;
    end
  end

`ifdef AVG_RD_OVERRUN_EN
  assign o_busy = (state == ISSUE) ||
                  (state == DRAIN);

  // sticky flag for starts dropped while busy
  always_ff @(posedge i_clk) begin
    if (i_reset)
      o_overrun <= 1'b0;
    else if (i_startRam && o_busy)
      o_overrun <= 1'b1;
  end
`endif

endmodule
